// File: rtl/seq_key_unlock_fsm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : seq_key_pkg                                                      |
// | Brief   : Shared types, default key sequence and width helpers for the     |
// |           key-sequence unlock controller.                                  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package seq_key_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_t;

    // Step 0 is the least significant word: A5, 3C, 5A, C3.
    localparam logic [31:0] C_DEFAULT_KEY_SEQ = 32'hC35A3CA5;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int f_cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int f_step_w(input int seq_len);
        return f_cnt_w(seq_len);
    endfunction

    function automatic int f_fail_w(input int max_fail);
        return f_cnt_w(max_fail);
    endfunction

endpackage : seq_key_pkg
`default_nettype wire

// File: rtl/seq_key_unlock_fsm_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : seq_key_unlock_fsm_if                                            |
// | Brief   : Key input / unlock status bundle between the key source          |
// |           (master) and the unlock controller (slave).                      |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface seq_key_unlock_fsm_if #(
    parameter int KEY_W  = 8,
    parameter int STEP_W = 3,
    parameter int FAIL_W = 2
);
    logic [KEY_W-1:0]  key_in;
    logic              key_vld;
    logic              relock;
    logic              unlocked;
    logic              obf_sel;
    logic              lockout;
    logic [STEP_W-1:0] step;
    logic [FAIL_W-1:0] fail_cnt;

    modport master (
        output key_in, key_vld, relock,
        input  unlocked, obf_sel, lockout, step, fail_cnt
    );

    modport slave (
        input  key_in, key_vld, relock,
        output unlocked, obf_sel, lockout, step, fail_cnt
    );
endinterface : seq_key_unlock_fsm_if
`default_nettype wire

// File: rtl/seq_key_unlock_fsm_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : seq_key_timer                                                    |
// | Brief   : Loadable down-counter with zero / last-count flags; stops at 0.  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module seq_key_timer #(
    parameter int W = 5
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_load,
    input  wire logic [W-1:0] i_load_val,
    input  wire logic         i_dec,
    output logic              o_zero,
    output logic              o_last
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);
    // A decrement while o_last is set is the edge on which the count reaches 0.
    assign o_last = (r_cnt == W'(1));

endmodule : seq_key_timer
`default_nettype wire

// File: rtl/seq_key_unlock_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : seq_key_unlock_fsm                                               |
// | Brief   : Multi-word key-sequence unlock controller with failure counting  |
// |           and timed lockout; drives obf_sel for a locked FSM.              |
// |           Optional macro SEQ_UNLOCK_TIMEOUT_EN adds an inter-key timeout.  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module seq_key_unlock_fsm
    import seq_key_pkg::*;
#(
    parameter int                         KEY_W       = 8,
    parameter int                         SEQ_LEN     = 4,
    parameter logic [SEQ_LEN*KEY_W-1:0]   KEY_SEQ     = C_DEFAULT_KEY_SEQ,
    parameter int                         MAX_FAIL    = 3,
    parameter int                         LOCKOUT_CYC = 16,
    parameter int                         TIMEOUT_CYC = 32
) (
    input  wire logic           clk,
    input  wire logic           rst,
    seq_key_unlock_fsm_if.slave bus
);
    localparam int STEP_W = f_step_w(SEQ_LEN);
    localparam int FAIL_W = f_fail_w(MAX_FAIL);
    localparam int LK_W   = f_cnt_w(LOCKOUT_CYC);

    localparam logic [STEP_W-1:0] C_STEP_LAST = STEP_W'(SEQ_LEN - 1);
    localparam logic [STEP_W-1:0] C_STEP_DONE = STEP_W'(SEQ_LEN);
    localparam logic [FAIL_W-1:0] C_FAIL_LAST = FAIL_W'(MAX_FAIL - 1);

    state_t            r_state;
    logic [STEP_W-1:0] r_step;
    logic [FAIL_W-1:0] r_fail_cnt;
    logic              r_unlocked;
    logic              r_obf_sel;
    logic              r_lockout;

    state_t            w_state_nxt;
    logic [STEP_W-1:0] w_step_nxt;
    logic [FAIL_W-1:0] w_fail_nxt;
    logic [KEY_W-1:0]  w_exp_key;
    logic              w_fail_evt;
    logic              w_lk_load;
    logic              w_lk_dec;
    logic              w_lk_zero;
    logic              w_lk_last;

    seq_key_timer #(.W(LK_W)) u_lk_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_lk_load),
        .i_load_val (LK_W'(LOCKOUT_CYC)),
        .i_dec      (w_lk_dec),
        .o_zero     (w_lk_zero),
        .o_last     (w_lk_last)
    );

`ifdef SEQ_UNLOCK_TIMEOUT_EN
    localparam int TO_W = f_cnt_w(TIMEOUT_CYC);

    logic w_to_load;
    logic w_to_dec;
    logic w_to_zero;
    logic w_to_last;

    seq_key_timer #(.W(TO_W)) u_to_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_to_load),
        .i_load_val (TO_W'(TIMEOUT_CYC)),
        .i_dec      (w_to_dec),
        .o_zero     (w_to_zero),
        .o_last     (w_to_last)
    );
`else
    // Without the timeout, partial progress is held until a key, relock or reset.
`endif

    // Word expected at the current step; only meaningful while step < SEQ_LEN.
    always_comb begin
        w_exp_key = '0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (r_step == STEP_W'(i)) begin
                w_exp_key = KEY_SEQ[i*KEY_W +: KEY_W];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_fail_nxt  = r_fail_cnt;
        w_fail_evt  = 1'b0;
        w_lk_load   = 1'b0;
        w_lk_dec    = 1'b0;
`ifdef SEQ_UNLOCK_TIMEOUT_EN
        w_to_load   = 1'b0;
        w_to_dec    = 1'b0;
`endif

        case (r_state)
            ST_LOCKED: begin
                if (bus.relock) begin
                    w_step_nxt = '0;
                end else if (bus.key_vld) begin
`ifdef SEQ_UNLOCK_TIMEOUT_EN
                    w_to_load = 1'b1;
`endif
                    if (bus.key_in == w_exp_key) begin
                        if (r_step == C_STEP_LAST) begin
                            w_state_nxt = ST_UNLOCKED;
                            w_step_nxt  = C_STEP_DONE;
                            w_fail_nxt  = '0;
                        end else begin
                            w_step_nxt  = r_step + 1'b1;
                        end
                    end else begin
                        w_fail_evt = 1'b1;
                    end
                end
`ifdef SEQ_UNLOCK_TIMEOUT_EN
                else if (r_step != '0) begin
                    // Silence after a partial match is treated as a wrong attempt.
                    w_to_dec = 1'b1;
                    if (w_to_last || w_to_zero) begin
                        w_fail_evt = 1'b1;
                    end
                end
`endif

                if (w_fail_evt) begin
                    w_step_nxt = '0;
                    if (r_fail_cnt == C_FAIL_LAST) begin
                        w_state_nxt = ST_LOCKOUT;
                        w_fail_nxt  = '0;
                        w_lk_load   = 1'b1;
                    end else begin
                        w_fail_nxt  = r_fail_cnt + 1'b1;
                    end
                end
            end

            ST_UNLOCKED: begin
                if (bus.relock) begin
                    w_state_nxt = ST_LOCKED;
                    w_step_nxt  = '0;
                    w_fail_nxt  = '0;
                end
            end

            ST_LOCKOUT: begin
                w_lk_dec = 1'b1;
                // Zero is only reachable here if the timer was disturbed; exit anyway.
                if (w_lk_last || w_lk_zero) begin
                    w_state_nxt = ST_LOCKED;
                end
            end

            default: begin
                w_state_nxt = ST_LOCKED;
                w_step_nxt  = '0;
                w_fail_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_LOCKED;
            r_step     <= '0;
            r_fail_cnt <= '0;
            r_unlocked <= 1'b0;
            r_obf_sel  <= 1'b0;
            r_lockout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_step     <= w_step_nxt;
            r_fail_cnt <= w_fail_nxt;
            r_unlocked <= (w_state_nxt == ST_UNLOCKED);
            r_obf_sel  <= (w_state_nxt == ST_UNLOCKED);
            r_lockout  <= (w_state_nxt == ST_LOCKOUT);
        end
    end

    assign bus.unlocked = r_unlocked;
    assign bus.obf_sel  = r_obf_sel;
    assign bus.lockout  = r_lockout;
    assign bus.step     = r_step;
    assign bus.fail_cnt = r_fail_cnt;

endmodule : seq_key_unlock_fsm
`default_nettype wire

// File: tb/tb_seq_key_unlock_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_seq_key_unlock_fsm                                            |
// | Brief   : Scoreboard bench for seq_key_unlock_fsm with a reference model.  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_seq_key_unlock_fsm;
    localparam int KEY_W       = 8;
    localparam int SEQ_LEN     = 4;
    localparam int MAX_FAIL    = 3;
    localparam int LOCKOUT_CYC = 16;
    localparam int TIMEOUT_CYC = 32;
    localparam int STEP_W      = $clog2(SEQ_LEN + 1);
    localparam int FAIL_W      = $clog2(MAX_FAIL + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_key_unlock_fsm_if #(.KEY_W(KEY_W), .STEP_W(STEP_W), .FAIL_W(FAIL_W)) bus ();

    seq_key_unlock_fsm #(
        .KEY_W       (KEY_W),
        .SEQ_LEN     (SEQ_LEN),
        .KEY_SEQ     (32'hC35A3CA5),
        .MAX_FAIL    (MAX_FAIL),
        .LOCKOUT_CYC (LOCKOUT_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit    unl;
        bit    lko;
        int    step;
        int    fail;
        string tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: progress through the sequence, failure tally, remaining lockout.
    bit m_unl;
    int m_step, m_fail, m_left, m_idle;

    function automatic logic [7:0] seq_word(input int i);
        logic [31:0] s;
        s = 32'hC35A3CA5;
        return s[i*8 +: 8];
    endfunction

    function automatic void m_reset();
        m_unl = 0; m_step = 0; m_fail = 0; m_left = 0; m_idle = 0;
    endfunction

    function automatic void m_failure();
        m_step = 0;
        m_idle = 0;
        m_fail++;
        if (m_fail == MAX_FAIL) begin
            m_fail = 0;
            m_left = LOCKOUT_CYC;
        end
    endfunction

    function automatic void m_clock(input bit kv, input logic [7:0] k, input bit rl);
        if (m_left > 0) begin
            m_left--;
            return;
        end
        if (m_unl) begin
            if (rl) begin
                m_unl = 0; m_step = 0; m_fail = 0;
            end
            return;
        end
        if (rl) begin
            m_step = 0;
            m_idle = 0;
            return;
        end
        if (kv) begin
            m_idle = 0;
            if (k == seq_word(m_step)) begin
                m_step++;
                if (m_step == SEQ_LEN) begin
                    m_unl  = 1;
                    m_fail = 0;
                end
            end else begin
                m_failure();
            end
            return;
        end
`ifdef SEQ_UNLOCK_TIMEOUT_EN
        if (m_step > 0) begin
            m_idle++;
            if (m_idle == TIMEOUT_CYC) m_failure();
        end
`endif
    endfunction

    function automatic exp_t m_expect(input string tag);
        exp_t e;
        e.unl  = m_unl;
        e.lko  = (m_left > 0);
        e.step = m_step;
        e.fail = m_fail;
        e.tag  = tag;
        return e;
    endfunction

    task automatic check(input exp_t e);
        n_checks++;
        if (bus.unlocked !== e.unl || bus.obf_sel !== e.unl || bus.lockout !== e.lko ||
            bus.step !== STEP_W'(e.step) || bus.fail_cnt !== FAIL_W'(e.fail)) begin
            n_errors++;
            $display("FAIL %s @%0t: got unl=%b obf=%b lko=%b step=%0d fail=%0d, want unl=%b obf=%b lko=%b step=%0d fail=%0d",
                     e.tag, $time, bus.unlocked, bus.obf_sel, bus.lockout, bus.step, bus.fail_cnt,
                     e.unl, e.unl, e.lko, e.step, e.fail);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare each against the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) check(sb_q.pop_front());
        end
    end

    task automatic drive(input bit kv, input logic [7:0] k, input bit rl, input string tag);
        @(negedge clk);
        bus.key_vld = kv;
        bus.key_in  = k;
        bus.relock  = rl;
        @(posedge clk);
        m_clock(kv, k, rl);
        sb_q.push_back(m_expect(tag));
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, tag);
    endtask

    task automatic unlock_seq(input string tag);
        for (int i = 0; i < SEQ_LEN; i++) drive(1'b1, seq_word(i), 1'b0, tag);
    endtask

    // Reset pulse between clock edges; the outputs must clear with no edge.
    task automatic async_reset_pulse(input string tag);
        @(negedge clk);
        bus.key_vld = 1'b0;
        bus.relock  = 1'b0;
        #2 rst = 1'b1;
        #1;
        sb_q.delete();
        m_reset();
        check(m_expect(tag));
        #1 rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bus.key_vld = 1'b0;
        bus.key_in  = '0;
        bus.relock  = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1 check(m_expect("reset_hold"));
        @(negedge clk);
        rst = 1'b0;
        idle(2, "reset_idle");

        unlock_seq("t1_unlock");
        idle(3, "t1_hold");
        drive(1'b1, 8'h00, 1'b0, "t1_key_ignored");
        drive(1'b0, 8'h00, 1'b1, "t4_relock");
        idle(1, "t4_after");

        drive(1'b1, 8'hA5, 1'b0, "t2_w0");
        drive(1'b1, 8'h3C, 1'b0, "t2_w1");
        drive(1'b1, 8'hFF, 1'b0, "t2_wrong");
        unlock_seq("t2_unlock");
        drive(1'b0, 8'h00, 1'b1, "t2_relock");

        drive(1'b1, 8'hA5, 1'b0, "t4_w0");
        drive(1'b1, 8'hA5, 1'b1, "t4_relock_wins");
        drive(1'b1, 8'h00, 1'b0, "t4_fail_step0");
        drive(1'b0, 8'h00, 1'b1, "t4_relock_keeps_fail");

        drive(1'b1, 8'h00, 1'b0, "t3_wrong");
        drive(1'b1, 8'h00, 1'b0, "t3_wrong");
        for (int i = 0; i < LOCKOUT_CYC + 2; i++)
            drive(1'b1, seq_word(i % SEQ_LEN), (i % 5) == 0, "t3_lockout");
        unlock_seq("t3_unlock_after");
        drive(1'b0, 8'h00, 1'b1, "t3_relock");

        for (int i = 0; i < MAX_FAIL; i++) drive(1'b1, 8'h00, 1'b0, "t5_wrong");
        idle(4, "t5_lockout");
        async_reset_pulse("t5_async_reset");
        unlock_seq("t5_unlock_after_reset");
        drive(1'b0, 8'h00, 1'b1, "t5_relock");

`ifdef SEQ_UNLOCK_TIMEOUT_EN
        drive(1'b1, 8'hA5, 1'b0, "t6_w0");
        idle(TIMEOUT_CYC, "t6_timeout");
        drive(1'b1, 8'hA5, 1'b0, "t6b_w0");
        idle(TIMEOUT_CYC - 1, "t6b_idle");
        drive(1'b1, 8'h3C, 1'b0, "t6b_w1_in_time");
        drive(1'b0, 8'h00, 1'b1, "t6_relock");
`endif

        for (int i = 0; i < 1500; i++) begin
            bit          kv, rl;
            logic [7:0]  k;
            kv = ($urandom_range(0, 3) != 0);
            rl = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 9) < 7 && m_step < SEQ_LEN) k = seq_word(m_step);
            else k = 8'($urandom);
            drive(kv, k, rl, "random");
            if ($urandom_range(0, 99) == 0) idle(TIMEOUT_CYC, "random_gap");
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_seq_key_unlock_fsm
`default_nettype wire
